// File: rtl/bfs_pkg.sv
// Shared types and constants for the BFS frontier enqueue arbiter.
package bfs_pkg;

  localparam int VID_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Queue lane enables; a lone lane-1 write (2'b10) is never legal.
  localparam logic [1:0] EQ_NONE = 2'b00;
  localparam logic [1:0] EQ_ONE  = 2'b01;
  localparam logic [1:0] EQ_TWO  = 2'b11;

endpackage

// File: rtl/rr_pick2.sv
// Combinational rotating-priority picker granting up to two requesters,
// scanning upward from rr_ptr with wrap at N_REQ.
module rr_pick2 #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    rr_ptr,
  output logic [N_REQ-1:0] g0,
  output logic [N_REQ-1:0] g1,
  output logic [IW-1:0]    idx0,
  output logic [IW-1:0]    idx1,
  output logic [1:0]       cnt
);

  always_comb begin
    int          p;
    logic [IW-1:0] pi;
    g0   = '0;
    g1   = '0;
    idx0 = '0;
    idx1 = '0;
    cnt  = 2'd0;
    p    = 0;
    pi   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      p = int'(rr_ptr) + k;
      if (p >= N_REQ) p = p - N_REQ;
      pi = IW'(p);
      if (req[pi]) begin
        if (cnt == 2'd0) begin
          g0[pi] = 1'b1;
          idx0   = pi;
          cnt    = 2'd1;
        end else if (cnt == 2'd1) begin
          g1[pi] = 1'b1;
          idx1   = pi;
          cnt    = 2'd2;
        end
      end
    end
  end

endmodule

// File: rtl/bfs_enq_arbiter.sv
// Round-robin arbiter packing up to two producer vertex IDs per beat into the
// dual-enqueue frontier queue, with level sequencing. Optional BFS_ENQ_STATS_EN.
module bfs_enq_arbiter
  import bfs_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int VID_W = bfs_pkg::VID_W
) (
  input  logic                     clk,
  input  logic                     bfs_rst,
  input  logic                     level_start,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*VID_W-1:0]   req_data,
  input  logic [N_REQ-1:0]         req_done,
  output logic [N_REQ-1:0]         req_ready,
  output logic [1:0]               enqueue_req,
  output logic [2*VID_W-1:0]       wdata_in,
  input  logic                     queue_full,
  output logic                     level_done,
  output logic                     busy
`ifdef BFS_ENQ_STATS_EN
  ,
  output logic [31:0]              stat_ids,
  output logic [31:0]              stat_stall
`endif
);

  localparam int IW = $clog2(N_REQ);

  state_t             state, state_nxt;
  logic [IW-1:0]      rr_ptr, rr_ptr_nxt, last_idx;
  logic [1:0]         enq_q;
  logic [2*VID_W-1:0] beat_q;

  logic               beat_vld, out_fire, can_grant, grant_any;
  logic [N_REQ-1:0]   req_masked, g0, g1;
  logic [IW-1:0]      idx0, idx1;
  logic [1:0]         cnt;
  logic [VID_W-1:0]   id0, id1, lane1;

  assign beat_vld  = (enq_q != EQ_NONE);
  assign out_fire  = beat_vld && !queue_full;
  // A new beat may only be loaded into an empty slot or one being drained now.
  assign can_grant = (state == ST_RUN) && (!beat_vld || out_fire);
  assign req_masked = can_grant ? req_valid : '0;

  rr_pick2 #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req    (req_masked),
    .rr_ptr (rr_ptr),
    .g0     (g0),
    .g1     (g1),
    .idx0   (idx0),
    .idx1   (idx1),
    .cnt    (cnt)
  );

  assign req_ready = g0 | g1;
  assign grant_any = (cnt != 2'd0);
  assign id0       = req_data[idx0*VID_W +: VID_W];
  assign id1       = req_data[idx1*VID_W +: VID_W];
  assign lane1     = (cnt == 2'd2) ? id1 : {VID_W{1'b0}};
  assign last_idx  = (cnt == 2'd2) ? idx1 : idx0;
  assign rr_ptr_nxt = (last_idx == IW'(N_REQ - 1)) ? '0 : last_idx + 1'b1;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (level_start) state_nxt = ST_RUN;
      ST_RUN:   if (&req_done && !(|req_valid)) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!beat_vld || out_fire) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign level_done  = (state == ST_DONE);
  assign busy        = (state != ST_IDLE);
  assign enqueue_req = enq_q;
  assign wdata_in    = beat_q;

  // Grant stage -> output beat register (latency 1)
  always_ff @(posedge clk or posedge bfs_rst) begin
    if (bfs_rst) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
      enq_q  <= EQ_NONE;
      beat_q <= '0;
    end else begin
      state <= state_nxt;
      if (grant_any) begin
        enq_q  <= (cnt == 2'd2) ? EQ_TWO : EQ_ONE;
        beat_q <= {lane1, id0};
        rr_ptr <= rr_ptr_nxt;
      end else if (out_fire) begin
        enq_q <= EQ_NONE;
      end
    end
  end

`ifdef BFS_ENQ_STATS_EN
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] inc);
    logic [32:0] s;
    s = {1'b0, a} + {31'b0, inc};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  logic [1:0] fire_ids;
  assign fire_ids = (enq_q == EQ_TWO) ? 2'd2 : 2'd1;

  always_ff @(posedge clk or posedge bfs_rst) begin
    if (bfs_rst) begin
      stat_ids   <= '0;
      stat_stall <= '0;
    end else if (level_start) begin
      stat_ids   <= '0;
      stat_stall <= '0;
    end else begin
      if (out_fire)              stat_ids   <= sat_add(stat_ids, fire_ids);
      if (beat_vld && queue_full) stat_stall <= sat_add(stat_stall, 2'd1);
    end
  end
`endif

endmodule

// File: tb/tb_bfs_enq_arbiter.sv
// Directed bench for bfs_enq_arbiter: gating, packing, backpressure, fairness, level end.
module tb_bfs_enq_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            bfs_rst = 1'b1;
  logic            level_start = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*32-1:0] req_data = '0;
  logic [N-1:0]    req_done = '0;
  logic [N-1:0]    req_ready;
  logic [1:0]      enqueue_req;
  logic [63:0]     wdata_in;
  logic            queue_full = 1'b0;
  logic            level_done;
  logic            busy;
`ifdef BFS_ENQ_STATS_EN
  logic [31:0]     stat_ids;
  logic [31:0]     stat_stall;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] granted_q[$];
  logic [31:0] accepted_q[$];

  always #5 clk = ~clk;

  bfs_enq_arbiter #(.N_REQ(N), .VID_W(32)) dut (
    .clk         (clk),
    .bfs_rst     (bfs_rst),
    .level_start (level_start),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_done    (req_done),
    .req_ready   (req_ready),
    .enqueue_req (enqueue_req),
    .wdata_in    (wdata_in),
    .queue_full  (queue_full),
    .level_done  (level_done),
    .busy        (busy)
`ifdef BFS_ENQ_STATS_EN
    ,
    .stat_ids    (stat_ids),
    .stat_stall  (stat_stall)
`endif
  );

  // Scoreboard collection: IDs handed over by producers and IDs taken by the queue.
  always @(negedge clk) begin
    if (!bfs_rst) begin
      for (int i = 0; i < N; i++)
        if (req_valid[i] && req_ready[i]) granted_q.push_back(req_data[i*32 +: 32]);
      if (enqueue_req != 2'b00 && !queue_full) begin
        accepted_q.push_back(wdata_in[31:0]);
        if (enqueue_req == 2'b11) accepted_q.push_back(wdata_in[63:32]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_level();
    level_start = 1'b1;
    step();
    level_start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
    n_cmp++; if (enqueue_req !== 2'b00) begin n_bad++; $display("FAIL reset_enq got=%b want=00", enqueue_req); end
    n_cmp++; if (wdata_in !== 64'h0) begin n_bad++; $display("FAIL reset_wdata got=%h want=0", wdata_in); end
    n_cmp++; if (level_done !== 1'b0) begin n_bad++; $display("FAIL reset_level_done got=%b want=0", level_done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    step();
    bfs_rst = 1'b0;
  endtask

  task automatic test_idle_gate();
    req_valid = 4'b0001;
    req_data[31:0] = 32'h1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (req_ready !== 4'b0000 || enqueue_req !== 2'b00 || busy !== 1'b0) begin
        n_bad++; $display("FAIL idle_gate cyc=%0d ready=%b enq=%b busy=%b want 0000/00/0", c, req_ready, enqueue_req, busy);
      end
      step();
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_packing();
    start_level();
    req_data[0*32 +: 32] = 32'hA;
    req_data[2*32 +: 32] = 32'hC;
    req_valid = 4'b0101;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL pack_busy got=%b want=1", busy); end
    n_cmp++; if (req_ready !== 4'b0101) begin n_bad++; $display("FAIL pack_ready got=%b want=0101", req_ready); end
    step();
    req_valid = 4'b0000;
    @(negedge clk);
    n_cmp++; if (enqueue_req !== 2'b11) begin n_bad++; $display("FAIL pack_enq got=%b want=11", enqueue_req); end
    n_cmp++; if (wdata_in !== 64'h0000000C_0000000A) begin n_bad++; $display("FAIL pack_wdata got=%h want=0000000c0000000a", wdata_in); end
    step();
    // rr_ptr should now be 3: all four requesting grants 3 then 0.
    for (int i = 0; i < N; i++) req_data[i*32 +: 32] = 32'hB0 + i;
    req_valid = 4'b1111;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b1001) begin n_bad++; $display("FAIL pack_ptr3_ready got=%b want=1001", req_ready); end
    n_cmp++; if (enqueue_req !== 2'b00) begin n_bad++; $display("FAIL pack_drained got=%b want=00", enqueue_req); end
    step();
    req_valid = 4'b0000;
    @(negedge clk);
    n_cmp++; if (wdata_in !== {32'hB0, 32'hB3} || enqueue_req !== 2'b11) begin
      n_bad++; $display("FAIL pack_wrap got=%b/%h want=11/000000b0000000b3", enqueue_req, wdata_in);
    end
    step();
  endtask

  task automatic test_single();
    req_data[2*32 +: 32] = 32'h55;
    req_valid = 4'b0100;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL single_ready got=%b want=0100", req_ready); end
    step();
    req_valid = 4'b0000;
    @(negedge clk);
    n_cmp++; if (enqueue_req !== 2'b01) begin n_bad++; $display("FAIL single_enq got=%b want=01", enqueue_req); end
    n_cmp++; if (wdata_in[31:0] !== 32'h55) begin n_bad++; $display("FAIL single_lane0 got=%h want=00000055", wdata_in[31:0]); end
    step();
    @(negedge clk);
    n_cmp++; if (enqueue_req !== 2'b00) begin n_bad++; $display("FAIL single_after got=%b want=00", enqueue_req); end
    step();
  endtask

  task automatic test_backpressure();
    granted_q.delete();
    accepted_q.delete();
    queue_full = 1'b1;
    req_data[0*32 +: 32] = 32'h100;
    req_data[1*32 +: 32] = 32'h101;
    req_valid = 4'b0011;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0011) begin n_bad++; $display("FAIL bp_first_ready got=%b want=0011", req_ready); end
    step();
    req_data[0*32 +: 32] = 32'h102;
    req_data[1*32 +: 32] = 32'h103;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (req_ready !== 4'b0000 || enqueue_req !== 2'b11 || wdata_in !== {32'h101, 32'h100}) begin
        n_bad++; $display("FAIL bp_hold cyc=%0d ready=%b enq=%b wdata=%h want 0000/11/0000010100000100", c, req_ready, enqueue_req, wdata_in);
      end
      step();
    end
    queue_full = 1'b0;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0011) begin n_bad++; $display("FAIL bp_release_ready got=%b want=0011", req_ready); end
    step();
    req_valid = 4'b0000;
    @(negedge clk);
    n_cmp++; if (enqueue_req !== 2'b11 || wdata_in !== {32'h103, 32'h102}) begin
      n_bad++; $display("FAIL bp_next_beat got=%b/%h want=11/0000010300000102", enqueue_req, wdata_in);
    end
    step();
    @(negedge clk);
    n_cmp++; if (enqueue_req !== 2'b00) begin n_bad++; $display("FAIL bp_empty got=%b want=00", enqueue_req); end
    step();
    n_cmp++; if (granted_q.size() != 4 || accepted_q.size() != 4) begin
      n_bad++; $display("FAIL bp_sb_count granted=%0d accepted=%0d want=4/4", granted_q.size(), accepted_q.size());
    end
    foreach (accepted_q[k]) begin
      int hit;
      hit = -1;
      foreach (granted_q[j]) if (hit < 0 && granted_q[j] === accepted_q[k]) hit = j;
      n_cmp++;
      if (hit < 0) begin n_bad++; $display("FAIL bp_sb_id got=%h want=an unconsumed granted ID", accepted_q[k]); end
      else granted_q.delete(hit);
    end
  endtask

  task automatic test_fairness();
    logic [31:0] lo, hi;
    bfs_rst = 1'b1;
    step();
    bfs_rst = 1'b0;
    start_level();
    for (int i = 0; i < N; i++) req_data[i*32 +: 32] = 32'h10 + i;
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++; if (req_ready !== ((k % 2 == 0) ? 4'b0011 : 4'b1100)) begin
        n_bad++; $display("FAIL fair_ready k=%0d got=%b want=%b", k, req_ready, (k % 2 == 0) ? 4'b0011 : 4'b1100);
      end
      if (k > 0) begin
        lo = (k % 2 == 1) ? 32'h10 : 32'h12;
        hi = (k % 2 == 1) ? 32'h11 : 32'h13;
        n_cmp++; if (enqueue_req !== 2'b11 || wdata_in !== {hi, lo}) begin
          n_bad++; $display("FAIL fair_beat k=%0d got=%b/%h want=11/%h", k, enqueue_req, wdata_in, {hi, lo});
        end
      end
      step();
    end
    req_valid = 4'b0000;
    @(negedge clk);
    n_cmp++; if (enqueue_req !== 2'b11 || wdata_in !== {32'h13, 32'h12}) begin
      n_bad++; $display("FAIL fair_last got=%b/%h want=11/0000001300000012", enqueue_req, wdata_in);
    end
    step();
  endtask

  task automatic test_level_end();
    queue_full = 1'b1;
    req_data[1*32 +: 32] = 32'h77;
    req_valid = 4'b0010;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL end_ready got=%b want=0010", req_ready); end
    step();
    req_valid = 4'b0000;
    req_done = 4'b1111;
    @(negedge clk);
    n_cmp++; if (enqueue_req !== 2'b01 || wdata_in[31:0] !== 32'h77) begin
      n_bad++; $display("FAIL end_beat got=%b/%h want=01/00000077", enqueue_req, wdata_in[31:0]);
    end
    step();
    req_valid = 4'b0001;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++; if (req_ready !== 4'b0000 || enqueue_req !== 2'b01 || level_done !== 1'b0 || busy !== 1'b1) begin
        n_bad++; $display("FAIL end_drain cyc=%0d ready=%b enq=%b done=%b busy=%b want 0000/01/0/1", c, req_ready, enqueue_req, level_done, busy);
      end
      step();
    end
    queue_full = 1'b0;
    req_valid = 4'b0000;
    @(negedge clk);
    n_cmp++; if (level_done !== 1'b0) begin n_bad++; $display("FAIL end_early_done got=%b want=0", level_done); end
    step();
    @(negedge clk);
    n_cmp++; if (level_done !== 1'b1 || enqueue_req !== 2'b00 || busy !== 1'b1) begin
      n_bad++; $display("FAIL end_done_pulse done=%b enq=%b busy=%b want 1/00/1", level_done, enqueue_req, busy);
    end
    step();
    @(negedge clk);
    n_cmp++; if (level_done !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL end_idle done=%b busy=%b want 0/0", level_done, busy);
    end
    step();
    req_done = 4'b0000;
  endtask

  task automatic test_reset_mid_run();
    start_level();
    queue_full = 1'b1;
    req_data[0*32 +: 32] = 32'h200;
    req_data[1*32 +: 32] = 32'h201;
    req_valid = 4'b0011;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0011) begin n_bad++; $display("FAIL rst_mid_ready got=%b want=0011", req_ready); end
    step();
    req_valid = 4'b0000;
    @(negedge clk);
    n_cmp++; if (enqueue_req !== 2'b11 || busy !== 1'b1) begin
      n_bad++; $display("FAIL rst_mid_pre enq=%b busy=%b want 11/1", enqueue_req, busy);
    end
    #2;
    bfs_rst = 1'b1;
    req_valid = 4'b0011;
    #1;
    n_cmp++; if (req_ready !== 4'b0000 || enqueue_req !== 2'b00 || wdata_in !== 64'h0 || level_done !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_async ready=%b enq=%b wdata=%h done=%b busy=%b want all 0", req_ready, enqueue_req, wdata_in, level_done, busy);
    end
    step();
    bfs_rst = 1'b0;
    queue_full = 1'b0;
    req_valid = 4'b0000;
    step();
    @(negedge clk);
    n_cmp++; if (enqueue_req !== 2'b00 || busy !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_after enq=%b busy=%b want 00/0", enqueue_req, busy);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_idle_gate();
    test_packing();
    test_single();
    test_backpressure();
    test_fairness();
    test_level_end();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
